// File: rtl/biquad_pkg.sv
// Shared types, widths and the round/saturate helper for the biquad sequencer.
package biquad_pkg;

  localparam int unsigned DW   = 16;
  localparam int unsigned CW   = 16;
  localparam int unsigned FRAC = 14;
  localparam int unsigned PW   = DW + CW;
  localparam int unsigned AW   = DW + CW + 3;
  localparam int unsigned NTAP = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_WB,
    S_OUT
  } state_t;

  localparam logic [2:0] TAP_B0 = 3'd0;
  localparam logic [2:0] TAP_B1 = 3'd1;
  localparam logic [2:0] TAP_B2 = 3'd2;
  localparam logic [2:0] TAP_A1 = 3'd3;
  localparam logic [2:0] TAP_A2 = 3'd4;

  localparam logic signed [AW-1:0] RND   = AW'(1 << (FRAC - 1));
  localparam logic signed [AW-1:0] Y_MAX = AW'((1 << (DW - 1)) - 1);
  localparam logic signed [AW-1:0] Y_MIN = AW'(-(1 << (DW - 1)));

  typedef struct packed {
    logic          sat;
    logic [DW-1:0] y;
  } rs_t;

  // Round half up, drop FRAC bits, clamp to the sample range.
  function automatic rs_t round_sat(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] r;
    rs_t res;
    r = (acc + RND) >>> FRAC;
    res.sat = 1'b0;
    if (r > Y_MAX) begin
      res.sat = 1'b1;
      res.y   = DW'(Y_MAX);
    end else if (r < Y_MIN) begin
      res.sat = 1'b1;
      res.y   = DW'(Y_MIN);
    end else begin
      res.y = DW'(r);
    end
    return res;
  endfunction

endpackage

// File: rtl/biquad_mac.sv
// Shared signed multiply-accumulate unit; control comes from the sequencer.
module biquad_mac
  import biquad_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 subtract,
  input  logic signed [CW-1:0] coef,
  input  logic signed [DW-1:0] operand,
  output logic signed [AW-1:0] acc
);

  logic signed [PW-1:0] prod_c;
  logic signed [AW-1:0] prod_ext_c;

  // Full-precision product, sign-extended to accumulator width.
  always_comb begin
    prod_c     = coef * operand;
    prod_ext_c = AW'(prod_c);
  end

  // Accumulator: clear has priority over accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= subtract ? (acc - prod_ext_c) : (acc + prod_ext_c);
    end
  end

endmodule

// File: rtl/biquad_sequencer.sv
// Cascade of NSEC Direct-Form-I biquads time-sharing one MAC, 6 cycles per section.
module biquad_sequencer
  import biquad_pkg::*;
#(
  parameter int unsigned NSEC = 2
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  input  logic                 cfg_we,
  output logic                 cfg_ready,
  input  logic [5:0]           cfg_addr,
  input  logic signed [CW-1:0] cfg_wdata,
  input  logic                 clr,
  output logic                 sat
);

  localparam int unsigned SEC_W = (NSEC > 1) ? $clog2(NSEC) : 1;

  state_t               state_q, state_d;
  logic [SEC_W-1:0]     sec_q;
  logic [2:0]           tap_q;
  logic signed [DW-1:0] xin_q;

  logic signed [CW-1:0] coef_q [NSEC][NTAP];
  logic signed [DW-1:0] x1_q [NSEC];
  logic signed [DW-1:0] x2_q [NSEC];
  logic signed [DW-1:0] y1_q [NSEC];
  logic signed [DW-1:0] y2_q [NSEC];

  logic signed [AW-1:0] acc;
  logic signed [CW-1:0] coef_c;
  logic signed [DW-1:0] operand_c;
  rs_t                  rs_c;

  logic accept_c, mac_clr_c, mac_en_c, mac_sub_c;
  logic wb_c, last_sec_c, out_done_c, clr_hit_c, cfg_hit_c;
  logic [2:0] cfg_sec_c, cfg_idx_c;

  biquad_mac u_mac (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .clear    (mac_clr_c),
    .enable   (mac_en_c),
    .subtract (mac_sub_c),
    .coef     (coef_c),
    .operand  (operand_c),
    .acc      (acc)
  );

  // Next-state and control decode.
  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    mac_clr_c  = 1'b0;
    mac_en_c   = 1'b0;
    wb_c       = 1'b0;
    out_done_c = 1'b0;
    clr_hit_c  = 1'b0;
    last_sec_c = (sec_q == SEC_W'(NSEC - 1));
    mac_sub_c  = (tap_q >= TAP_A1);
    case (state_q)
      S_IDLE: begin
        clr_hit_c = clr;
        if (in_valid && in_ready) begin
          accept_c  = 1'b1;
          mac_clr_c = 1'b1;
          state_d   = S_MAC;
        end
      end
      S_MAC: begin
        mac_en_c = 1'b1;
        if (tap_q == TAP_A2) state_d = S_WB;
      end
      S_WB: begin
        wb_c      = 1'b1;
        mac_clr_c = 1'b1;
        state_d   = last_sec_c ? S_OUT : S_MAC;
      end
      S_OUT: begin
        if (out_valid && out_ready) begin
          out_done_c = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand and coefficient selection for the current tap.
  always_comb begin
    coef_c = coef_q[sec_q][tap_q];
    case (tap_q)
      TAP_B0:  operand_c = xin_q;
      TAP_B1:  operand_c = x1_q[sec_q];
      TAP_B2:  operand_c = x2_q[sec_q];
      TAP_A1:  operand_c = y1_q[sec_q];
      TAP_A2:  operand_c = y2_q[sec_q];
      default: operand_c = '0;
    endcase
    rs_c = round_sat(acc);
  end

  // Coefficient write decode; out-of-range section or tap is ignored.
  always_comb begin
    cfg_sec_c = cfg_addr[5:3];
    cfg_idx_c = cfg_addr[2:0];
    cfg_hit_c = cfg_we && cfg_ready && (cfg_idx_c <= TAP_A2) &&
                (32'(cfg_sec_c) < NSEC);
  end

  // State register and registered handshake outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      in_ready  <= 1'b1;
      cfg_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == S_IDLE);
      cfg_ready <= (state_d == S_IDLE);
    end
  end

  // Sequencing counters, section input and output register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sec_q     <= '0;
      tap_q     <= '0;
      xin_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
    end else begin
      if (clr_hit_c) sat <= 1'b0;
      if (accept_c) begin
        xin_q <= in_data;
        sec_q <= '0;
        tap_q <= '0;
      end
      if (mac_en_c) tap_q <= tap_q + 3'd1;
      if (wb_c) begin
        xin_q <= rs_c.y;
        tap_q <= '0;
        if (rs_c.sat) sat <= 1'b1;
        if (last_sec_c) begin
          out_data  <= rs_c.y;
          out_valid <= 1'b1;
        end else begin
          sec_q <= sec_q + SEC_W'(1);
        end
      end
      if (out_done_c) out_valid <= 1'b0;
    end
  end

  // Per-section delay lines: cleared by clr in idle, shifted on write-back.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      x1_q <= '{default: '0};
      x2_q <= '{default: '0};
      y1_q <= '{default: '0};
      y2_q <= '{default: '0};
    end else if (clr_hit_c) begin
      x1_q <= '{default: '0};
      x2_q <= '{default: '0};
      y1_q <= '{default: '0};
      y2_q <= '{default: '0};
    end else if (wb_c) begin
      x2_q[sec_q] <= x1_q[sec_q];
      x1_q[sec_q] <= xin_q;
      y2_q[sec_q] <= y1_q[sec_q];
      y1_q[sec_q] <= rs_c.y;
    end
  end

  // Coefficient register file, writable only while idle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      coef_q <= '{default: '0};
    end else if (cfg_hit_c) begin
      coef_q[SEC_W'(cfg_sec_c)][cfg_idx_c] <= cfg_wdata;
    end
  end

endmodule

// File: doc/biquad_sequencer.md
Name: biquad_sequencer

Overview:
Controller for a cascade of NSEC Direct-Form-I biquad sections that share one multiply-accumulate unit. It accepts one input sample over a valid/ready handshake and steps the shared MAC through 5 taps per section. After each section it rounds, saturates and updates that section's delay line, then chains the result into the next section. It holds the coefficient register file and sits between the user-project sample source and the mprj_io output driver.

Parameters:
DW, 16, signed sample width
CW, 16, signed coefficient width
FRAC, 14, coefficient fraction bits (Q2.14)
NSEC, 2, number of cascaded sections (1..8)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  asynchronous active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  sequencer can accept a sample
in_data  in  DW  signed input sample
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  DW  signed filtered sample
cfg_we  in  1  coefficient write strobe
cfg_ready  out  1  coefficient write will be honoured
cfg_addr  in  6  {sec[2:0], idx[2:0]}; idx 0..4 = b0,b1,b2,a1,a2
cfg_wdata  in  CW  signed coefficient
clr  in  1  clear delay lines and sat flag
sat  out  1  sticky saturation flag

Behaviour:
- Reset values:
  - FSM = IDLE; in_ready=1, out_valid=0, out_data=0, sat=0, cfg_ready=1.
  - All coefficients and all delay lines (x1,x2,y1,y2 per section) = 0.
  - Accumulator = 0; sec = 0; tap = 0.
- FSM states: IDLE, MAC, WB, OUT.
- IDLE:
  - in_ready=1 and cfg_ready=1.
  - On in_valid && in_ready: latch in_data as the section input xin, sec=0, tap=0, acc=0, go to MAC.
- MAC: at each edge, acc += sign(tap) * (coef[sec][tap] * operand[tap]), then tap++.
  - Operands by tap 0..4: xin, x1, x2, y1, y2.
  - sign = + for taps 0..2 and - for taps 3..4.
  - After the tap-4 edge, go to WB.
- WB, single edge:
  - y = saturate_DW((acc + 2^(FRAC-1)) >>> FRAC), i.e. round half up, arithmetic shift.
  - Update the section delay line: x2<=x1, x1<=xin, y2<=y1, y1<=y.
  - xin<=y; acc<=0; tap<=0.
  - If sec==NSEC-1: out_data<=y, out_valid<=1, go to OUT. Otherwise sec++ and go to MAC.
- Timing: 6 cycles per section. out_valid rises exactly 6*NSEC edges after the accept edge (12 for NSEC=2).
- OUT:
  - out_data is held stable until out_valid && out_ready. On that edge out_valid<=0 and the FSM returns to IDLE.
  - in_ready=0 in OUT; there is no overlap of consecutive samples.
  - Throughput is one sample per 6*NSEC+2 cycles with out_ready held high.
- Arithmetic: products are DW+CW signed bits; acc is DW+CW+3 bits, so no internal overflow is possible. Saturation clamps to [-2^(DW-1), 2^(DW-1)-1] and sets sat, which stays set until clr or reset.
- Coefficient writes:
  - Written only when cfg_we && cfg_ready, i.e. in IDLE.
  - Writes while busy are dropped, with no side effects.
  - Writes with idx>4 or sec>=NSEC are ignored.
- clr:
  - Honoured only in IDLE: zeroes all delay lines and sat in one cycle; coefficients are kept.
  - If in_valid and clr arrive on the same edge, clr applies first and the sample is accepted against the cleared state.
  - clr outside IDLE is ignored.
- Reset mid-operation: asynchronous. All state returns to reset values immediately, and the partial sample is discarded with no output.

Decomposition:
- Package biquad_pkg:
  - FSM state enum.
  - Tap index constants B0..A2 = 0..4.
  - Localparam AW = DW+CW+3.
  - Rounding/saturation function.
- Sub-module biquad_mac:
  - Signed multiplier and AW-bit accumulator.
  - Inputs: clear, enable, subtract.
  - Output: the accumulator value.
  - The sequencer owns all control and storage.

Test Plan:
- Passthrough, NSEC=2: b0=16384 in both sections, others 0. x=1234 -> out_data=1234, out_valid exactly 12 cycles after accept, sat=0.
- Impulse response: sec0 b0=8192, a1=-8192; sec1 b0=16384. Send x=1000,0,0,0,0 -> outputs 500,250,125,63,32.
- Saturation: sec0 b0=32767, sec1 unity. x=30000 -> out_data=32767 and sat=1. Then clr in IDLE -> sat=0, delay lines 0.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_data stable, in_ready=0, upstream in_valid held. Release -> handshake completes and in_ready=1 on the next cycle.
- Config guard: cfg_we during MAC -> cfg_ready=0 and coefficient unchanged (verified via the next sample's output). Write to idx=5 -> no effect.
- Reset mid-MAC: assert wb_rst_i 4 cycles after accept -> out_valid=0 and in_ready=1 immediately. Coefficients read back as zero, so the next sample outputs 0.
